// File: rtl/pw_lock_core_if.sv
// pw_lock_core_if: button inputs and display/status outputs of pw_lock_core.
// master drives the buttons, slave is the lock core.
interface pw_lock_core_if #(
    parameter int DIGITS = 4
);
    logic                  up;
    logic                  down;
    logic                  slide;
    logic                  ok;
    logic                  pw_endset;
    logic                  pw_set;
    logic [4*DIGITS-1:0]   entry;
    logic [2:0]            cursor;
    logic [1:0]            status;
    logic                  unlock;
    logic                  fail;
    logic [3:0]            fail_cnt;
    logic                  in_set;

    modport master (
        output up, down, slide, ok, pw_endset, pw_set,
        input  entry, cursor, status, unlock, fail, fail_cnt, in_set
    );

    modport slave (
        input  up, down, slide, ok, pw_endset, pw_set,
        output entry, cursor, status, unlock, fail, fail_cnt, in_set
    );
endinterface

// File: rtl/pw_lock_core.sv
// pw_lock_core: digit-entry password lock with an edit mode for the password.
// Define PW_LOCKOUT_EN to add the timed LOCKOUT state after MAX_FAIL misses.
module pw_lock_core #(
    parameter int DIGITS      = 4,
    parameter int RADIX       = 10,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 1000
) (
    input  logic          clk,
    input  logic          rst,
    pw_lock_core_if.slave bus
);
    localparam int         W    = 4 * DIGITS;
    localparam logic [3:0] TOP  = 4'(RADIX - 1);
    localparam logic [2:0] LAST = 3'(DIGITS - 1);

    localparam int B_DOWN  = 0;
    localparam int B_UP    = 1;
    localparam int B_SLIDE = 2;
    localparam int B_OK    = 3;
    localparam int B_END   = 4;
    localparam int B_SET   = 5;

    if (DIGITS < 2 || DIGITS > 8 || RADIX < 2 || RADIX > 16 ||
        MAX_FAIL < 1 || MAX_FAIL > 15 ||
        LOCK_CYCLES < 1 || LOCK_CYCLES > 1048575) begin : g_bad_param
        $error("pw_lock_core: parameter out of range");
    end

`ifdef PW_LOCKOUT_EN
    typedef enum logic [1:0] {BASIC, SET, LOCKOUT} state_t;
`else
    typedef enum logic [1:0] {BASIC, SET} state_t;
`endif

    state_t         state;
    logic           run;
    logic [5:0]     btn;
    logic [5:0]     prev;
    logic [5:0]     rise;
    logic           set_fall;
    logic [W-1:0]   entry;
    logic [W-1:0]   pw;
    logic [W-1:0]   inc_entry;
    logic [W-1:0]   dec_entry;
    logic [2:0]     cursor;
    logic [2:0]     cursor_next;
    logic [1:0]     status;
    logic           unlock;
    logic           fail;
    logic           in_set;
    logic [3:0]     fail_cnt;
    logic [3:0]     fail_inc;
`ifdef PW_LOCKOUT_EN
    logic [19:0]    lock_cnt;
`endif

    assign btn = {bus.pw_set, bus.pw_endset, bus.ok,
                  bus.slide, bus.up, bus.down};

    // run stays low for the first edge after reset so that buttons
    // already held at release only seed the history, never fire.
    assign rise     = run ? (btn & ~prev) : 6'b0;
    assign set_fall = run & prev[B_SET] & ~btn[B_SET];

    assign cursor_next = (cursor == LAST) ? 3'd0 : cursor + 3'd1;
    assign fail_inc    = (fail_cnt == 4'hF) ? 4'hF : fail_cnt + 4'd1;

    // Candidate entries with the digit under the cursor stepped up/down.
    always_comb begin
        inc_entry = entry;
        dec_entry = entry;
        for (int i = 0; i < DIGITS; i++) begin
            if (cursor == 3'(i)) begin
                inc_entry[4*i +: 4] = (entry[4*i +: 4] == TOP) ?
                                      4'd0 : entry[4*i +: 4] + 4'd1;
                dec_entry[4*i +: 4] = (entry[4*i +: 4] == 4'd0) ?
                                      TOP : entry[4*i +: 4] - 4'd1;
            end
        end
    end

    // Mode FSM: one prioritised button action per cycle, registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= BASIC;
            run      <= 1'b0;
            prev     <= '0;
            entry    <= '0;
            pw       <= '0;
            cursor   <= '0;
            status   <= 2'b00;
            unlock   <= 1'b0;
            fail     <= 1'b0;
            fail_cnt <= '0;
            in_set   <= 1'b0;
`ifdef PW_LOCKOUT_EN
            lock_cnt <= '0;
`endif
        end else begin
            run    <= 1'b1;
            prev   <= btn;
            unlock <= 1'b0;
            fail   <= 1'b0;
            unique case (state)
                BASIC: begin
                    if (rise[B_OK]) begin
                        entry  <= '0;
                        cursor <= '0;
                        if (entry == pw) begin
                            unlock   <= 1'b1;
                            status   <= 2'b01;
                            fail_cnt <= '0;
                        end else begin
                            fail     <= 1'b1;
                            status   <= 2'b10;
                            fail_cnt <= fail_inc;
`ifdef PW_LOCKOUT_EN
                            if (fail_inc >= 4'(MAX_FAIL)) begin
                                state    <= LOCKOUT;
                                status   <= 2'b11;
                                lock_cnt <= 20'(LOCK_CYCLES);
                            end
`endif
                        end
                    end else if (rise[B_SET]) begin
                        state  <= SET;
                        in_set <= 1'b1;
                        entry  <= '0;
                        cursor <= '0;
                        status <= 2'b00;
                    end else if (rise[B_SLIDE]) begin
                        cursor <= cursor_next;
                        status <= 2'b00;
                    end else if (rise[B_UP]) begin
                        entry  <= inc_entry;
                        status <= 2'b00;
                    end else if (rise[B_DOWN]) begin
                        entry  <= dec_entry;
                        status <= 2'b00;
                    end
                end
                SET: begin
                    if (rise[B_END]) begin
                        pw     <= entry;
                        entry  <= '0;
                        cursor <= '0;
                        state  <= BASIC;
                        in_set <= 1'b0;
                    end else if (set_fall) begin
                        entry  <= '0;
                        cursor <= '0;
                        state  <= BASIC;
                        in_set <= 1'b0;
                    end else if (rise[B_SLIDE]) begin
                        cursor <= cursor_next;
                    end else if (rise[B_UP]) begin
                        entry <= inc_entry;
                    end else if (rise[B_DOWN]) begin
                        entry <= dec_entry;
                    end
                end
`ifdef PW_LOCKOUT_EN
                LOCKOUT: begin
                    lock_cnt <= lock_cnt - 20'd1;
                    if (lock_cnt == 20'd1) begin
                        state    <= BASIC;
                        fail_cnt <= '0;
                        status   <= 2'b00;
                    end
                end
`endif
                default: state <= BASIC;
            endcase
        end
    end

    assign bus.entry    = entry;
    assign bus.cursor   = cursor;
    assign bus.status   = status;
    assign bus.unlock   = unlock;
    assign bus.fail     = fail;
    assign bus.fail_cnt = fail_cnt;
    assign bus.in_set   = in_set;
endmodule

// File: tb/tb_pw_lock_core.sv
// tb_pw_lock_core: two lock cores (4x radix-10 and 6x radix-16) fed the same
// buttons, each compared against a digit-array model of the lock.
module tb_pw_lock_core;
`ifdef PW_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif
    localparam int LOCKN = 1000;

    localparam logic [6:0] E_D  = 7'h01;
    localparam logic [6:0] E_U  = 7'h02;
    localparam logic [6:0] E_S  = 7'h04;
    localparam logic [6:0] E_OK = 7'h08;
    localparam logic [6:0] E_E  = 7'h10;
    localparam logic [6:0] E_SR = 7'h20;
    localparam logic [6:0] E_SF = 7'h40;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic up = 1'b0, down = 1'b0, slide = 1'b0, ok = 1'b0;
    logic pw_endset = 1'b0, pw_set = 1'b0;

    int cyc = 0;
    int checks = 0;
    int passes = 0;

    int m_dig [2][8];
    int m_pw [2][8];
    int m_cur [2];
    int m_stat [2];
    int m_fcnt [2];
    int m_mode [2];
    int m_unl [2];
    int m_fl [2];
    int m_lend [2];

    pw_lock_core_if #(.DIGITS(4)) bus0 ();
    pw_lock_core_if #(.DIGITS(6)) bus1 ();

    assign bus0.up = up;        assign bus1.up = up;
    assign bus0.down = down;    assign bus1.down = down;
    assign bus0.slide = slide;  assign bus1.slide = slide;
    assign bus0.ok = ok;        assign bus1.ok = ok;
    assign bus0.pw_endset = pw_endset;
    assign bus1.pw_endset = pw_endset;
    assign bus0.pw_set = pw_set;
    assign bus1.pw_set = pw_set;

    pw_lock_core #(.DIGITS(4), .RADIX(10), .MAX_FAIL(3),
                   .LOCK_CYCLES(LOCKN)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0));

    pw_lock_core #(.DIGITS(6), .RADIX(16), .MAX_FAIL(15),
                   .LOCK_CYCLES(LOCKN)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    function automatic int dign(int d);
        return (d == 0) ? 4 : 6;
    endfunction

    function automatic int radn(int d);
        return (d == 0) ? 10 : 16;
    endfunction

    function automatic int maxf(int d);
        return (d == 0) ? 3 : 15;
    endfunction

    function automatic logic [43:0] obs_of(int d);
        if (d == 0)
            return {16'h0, bus0.entry, bus0.cursor, bus0.status, bus0.unlock,
                    bus0.fail, bus0.fail_cnt, bus0.in_set};
        return {8'h0, bus1.entry, bus1.cursor, bus1.status, bus1.unlock,
                bus1.fail, bus1.fail_cnt, bus1.in_set};
    endfunction

    function automatic logic [43:0] exp_of(int d);
        logic [31:0] e;
        e = '0;
        for (int i = 0; i < dign(d); i++) e[4*i +: 4] = 4'(m_dig[d][i]);
        return {e, 3'(m_cur[d]), 2'(m_stat[d]), m_unl[d] == cyc,
                m_fl[d] == cyc, 4'(m_fcnt[d]), m_mode[d] == 1};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                m_dig[d][i] = 0;
                m_pw[d][i] = 0;
            end
            m_cur[d] = 0; m_stat[d] = 0; m_fcnt[d] = 0; m_mode[d] = 0;
            m_unl[d] = -1; m_fl[d] = -1; m_lend[d] = 0;
        end
    endtask

    task automatic model_clear(int d);
        for (int i = 0; i < 8; i++) m_dig[d][i] = 0;
        m_cur[d] = 0;
    endtask

    task automatic model_edit(int d, logic [6:0] ev);
        int c;
        c = m_cur[d];
        if (ev[2]) m_cur[d] = (c + 1) % dign(d);
        else if (ev[1]) m_dig[d][c] = (m_dig[d][c] + 1) % radn(d);
        else if (ev[0]) m_dig[d][c] = (m_dig[d][c] + radn(d) - 1) % radn(d);
    endtask

    task automatic model_apply(int d, logic [6:0] ev);
        bit match;
        if (m_mode[d] == 2) begin
            if (cyc <= m_lend[d]) return;
            m_mode[d] = 0; m_stat[d] = 0; m_fcnt[d] = 0;
        end
        if (m_mode[d] == 0) begin
            if (ev[3]) begin
                match = 1'b1;
                for (int i = 0; i < dign(d); i++)
                    if (m_dig[d][i] != m_pw[d][i]) match = 1'b0;
                if (match) begin
                    m_unl[d] = cyc; m_stat[d] = 1; m_fcnt[d] = 0;
                end else begin
                    m_fl[d] = cyc; m_stat[d] = 2;
                    if (m_fcnt[d] < 15) m_fcnt[d]++;
                    if (LOCK_EN && m_fcnt[d] >= maxf(d)) begin
                        m_mode[d] = 2; m_stat[d] = 3;
                        m_lend[d] = cyc + LOCKN;
                    end
                end
                model_clear(d);
            end else if (ev[5]) begin
                m_mode[d] = 1; m_stat[d] = 0;
                model_clear(d);
            end else if (|ev[2:0]) begin
                model_edit(d, ev);
                m_stat[d] = 0;
            end
        end else begin
            if (ev[4]) begin
                for (int i = 0; i < 8; i++) m_pw[d][i] = m_dig[d][i];
                model_clear(d);
                m_mode[d] = 0;
            end else if (ev[6]) begin
                model_clear(d);
                m_mode[d] = 0;
            end else begin
                model_edit(d, ev);
            end
        end
    endtask

    task automatic resolve();
        for (int d = 0; d < 2; d++)
            if (m_mode[d] == 2 && cyc >= m_lend[d]) begin
                m_mode[d] = 0; m_stat[d] = 0; m_fcnt[d] = 0;
            end
    endtask

    task automatic do_step(logic [6:0] ev);
        @(negedge clk);
        {pw_endset, ok, slide, up, down} = ev[4:0];
        if (ev[5]) pw_set = 1'b1;
        if (ev[6]) pw_set = 1'b0;
        @(posedge clk);
        #1;
        model_apply(0, ev);
        model_apply(1, ev);
        resolve();
        @(negedge clk);
        {pw_endset, ok, slide, up, down} = 5'b0;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_of(d) !== exp_of(d))
                $display("FAIL reset dut%0d got %h want %h",
                         d, obs_of(d), exp_of(d));
            else passes++;
        end
        up = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        resolve();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_of(d) !== exp_of(d))
                $display("FAIL held_button dut%0d got %h want %h",
                         d, obs_of(d), exp_of(d));
            else passes++;
        end
        up = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus0.entry !== 16'h0)
            $display("FAIL held_button_entry got %h want 0000", bus0.entry);
        else passes++;
    endtask

    task automatic test_default_open();
        do_step(E_OK);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_of(d) !== exp_of(d))
                $display("FAIL default_open dut%0d got %h want %h",
                         d, obs_of(d), exp_of(d));
            else passes++;
        end
        checks++;
        if ({bus0.unlock, bus0.status} !== 3'b101)
            $display("FAIL default_open_pulse got %b want 101",
                     {bus0.unlock, bus0.status});
        else passes++;
    endtask

    task automatic test_set_password();
        logic [6:0] s1 [12] = '{E_SR, E_U, E_U, E_U, E_D, E_S, E_U,
                                E_S, E_S, E_D, E_E, E_SF};
        logic [6:0] s2 [7] = '{E_U, E_U, E_S, E_U, E_S, E_S, E_D};
        for (int i = 0; i < 12; i++) begin
            do_step(s1[i]);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_of(d) !== exp_of(d))
                    $display("FAIL set_pw step%0d dut%0d got %h want %h",
                             i, d, obs_of(d), exp_of(d));
                else passes++;
            end
        end
        for (int i = 0; i < 7; i++) begin
            do_step(s2[i]);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_of(d) !== exp_of(d))
                    $display("FAIL enter_pw step%0d dut%0d got %h want %h",
                             i, d, obs_of(d), exp_of(d));
                else passes++;
            end
        end
        checks++;
        if (bus0.entry !== 16'h9012)
            $display("FAIL entry_2109 got %h want 9012", bus0.entry);
        else passes++;
        do_step(E_OK);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_of(d) !== exp_of(d))
                $display("FAIL open_2109 dut%0d got %h want %h",
                         d, obs_of(d), exp_of(d));
            else passes++;
        end
        checks++;
        if (bus0.unlock !== 1'b1)
            $display("FAIL open_2109_pulse got %b want 1", bus0.unlock);
        else passes++;
    endtask

    task automatic test_lockout();
        logic [6:0] s [5] = '{E_S, E_S, E_S, E_U, E_OK};
        for (int k = 1; k <= 3; k++) begin
            for (int i = 0; i < 5; i++) begin
                do_step(s[i]);
                for (int d = 0; d < 2; d++) begin
                    checks++;
                    if (obs_of(d) !== exp_of(d))
                        $display("FAIL wrong%0d step%0d dut%0d got %h want %h",
                                 k, i, d, obs_of(d), exp_of(d));
                    else passes++;
                end
            end
            checks++;
            if ({bus0.fail, bus0.fail_cnt} !== {1'b1, 4'(k)})
                $display("FAIL fail_cnt%0d got %h want %h",
                         k, {bus0.fail, bus0.fail_cnt}, {1'b1, 4'(k)});
            else passes++;
        end
        checks++;
        if (bus0.status !== (LOCK_EN ? 2'b11 : 2'b10))
            $display("FAIL lock_status got %b want %b",
                     bus0.status, LOCK_EN ? 2'b11 : 2'b10);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            do_step(E_U);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_of(d) !== exp_of(d))
                    $display("FAIL locked_press%0d dut%0d got %h want %h",
                             i, d, obs_of(d), exp_of(d));
                else passes++;
            end
        end
        checks++;
        if (bus0.entry !== (LOCK_EN ? 16'h0000 : 16'h0003))
            $display("FAIL locked_entry got %h want %h",
                     bus0.entry, LOCK_EN ? 16'h0000 : 16'h0003);
        else passes++;
        repeat (520) do_step(7'h00);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_of(d) !== exp_of(d))
                $display("FAIL lock_exit dut%0d got %h want %h",
                         d, obs_of(d), exp_of(d));
            else passes++;
        end
        checks++;
        if (bus0.fail_cnt !== (LOCK_EN ? 4'd0 : 4'd3))
            $display("FAIL lock_exit_cnt got %0d want %0d",
                     bus0.fail_cnt, LOCK_EN ? 0 : 3);
        else passes++;
    endtask

    task automatic test_radix16();
        logic [6:0] s [9] = '{E_OK, E_D, E_S, E_S, E_S, E_S, E_S, E_S,
                              E_U | E_OK};
        for (int i = 0; i < 9; i++) begin
            do_step(s[i]);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_of(d) !== exp_of(d))
                    $display("FAIL radix16 step%0d dut%0d got %h want %h",
                             i, d, obs_of(d), exp_of(d));
                else passes++;
            end
            if (i == 1) begin
                checks++;
                if (bus1.entry[3:0] !== 4'hF)
                    $display("FAIL down_wrap got %h want f", bus1.entry[3:0]);
                else passes++;
            end
            if (i == 7) begin
                checks++;
                if (bus1.cursor !== 3'd0)
                    $display("FAIL slide_wrap got %0d want 0", bus1.cursor);
                else passes++;
            end
        end
        checks++;
        if ({bus1.entry, bus1.fail} !== {24'h0, 1'b1})
            $display("FAIL ok_over_up got %h want %h",
                     {bus1.entry, bus1.fail}, {24'h0, 1'b1});
        else passes++;
    endtask

    task automatic test_abort_and_reset();
        logic [6:0] s [20] = '{E_U, E_U, E_S, E_U, E_S, E_S, E_D, E_OK,
                               E_SR, E_U, E_S, E_U, E_SF,
                               E_U, E_U, E_S, E_U, E_S, E_S, E_D};
        for (int i = 0; i < 20; i++) begin
            do_step(s[i]);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_of(d) !== exp_of(d))
                    $display("FAIL abort step%0d dut%0d got %h want %h",
                             i, d, obs_of(d), exp_of(d));
                else passes++;
            end
        end
        do_step(E_OK);
        checks++;
        if ({bus0.unlock, bus1.unlock} !== 2'b11)
            $display("FAIL abort_keeps_pw got %b want 11",
                     {bus0.unlock, bus1.unlock});
        else passes++;
        do_step(E_SR);
        do_step(E_U);
        do_step(E_U);
        rst = 1'b0;
        #1;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_of(d) !== exp_of(d))
                $display("FAIL reset_in_set dut%0d got %h want %h",
                         d, obs_of(d), exp_of(d));
            else passes++;
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        do_step(E_SF);
        do_step(E_OK);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_of(d) !== exp_of(d))
                $display("FAIL zero_pw dut%0d got %h want %h",
                         d, obs_of(d), exp_of(d));
            else passes++;
        end
        checks++;
        if ({bus1.unlock, bus1.in_set} !== 2'b10)
            $display("FAIL zero_pw_unlock got %b want 10",
                     {bus1.unlock, bus1.in_set});
        else passes++;
    endtask

    task automatic test_random();
        logic [6:0] ev;
        int r;
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 5);
            if (!pw_set) begin
                unique case (r)
                    0: ev = E_D;
                    1: ev = E_U;
                    2: ev = E_S;
                    3: ev = E_OK;
                    4: ev = E_E;
                    default: ev = E_SR;
                endcase
            end else begin
                unique case (r)
                    0: ev = E_D;
                    1: ev = E_U;
                    2: ev = E_S;
                    3: ev = E_OK;
                    4: ev = E_E;
                    default: ev = E_SF;
                endcase
            end
            if ($urandom_range(0, 4) == 0)
                ev[$urandom_range(0, 4)] = 1'b1;
            do_step(ev);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_of(d) !== exp_of(d))
                    $display("FAIL random%0d ev=%h dut%0d got %h want %h",
                             n, ev, d, obs_of(d), exp_of(d));
                else passes++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_open();
        test_set_password();
        test_lockout();
        test_radix16();
        test_abort_and_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
